pe_sequencer: RTL and testbench
===============================

# pe_sequencer

Control FSM for one systolic processing element. It drives the datapath control strobes (`act_BOOTH`, `load_in_exp_PIPO`, `clr_in_exp_PIPO`, `clr_result_PIPO`, `clr_status_reg`) and consumes the datapath's `delayed_done`. It sequences a K-term multiply-accumulate: one clear, then K rounds of load, multiply and wait-for-done. It sits between the array-level scheduler (start/operand handshake) and `ProcessingElement_DATAPATH`.

## Interface
Parameters:
- `K_DEPTH`, default 4: products accumulated per result (≥1).
- `CNT_W`, default 3: width of the term counter; must satisfy 2^CNT_W ≥ K_DEPTH.
- `TIMEOUT`, default 31: maximum WAIT cycles before error (≥1, <256).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a K-term accumulation; sampled only in IDLE.
- `abort`  in  1  abandon the current operation; return to IDLE via CLEAR.
- `operand_valid`  in  1  upstream presents `in1`/`in2` to the datapath.
- `operand_ready`  out  1  sequencer accepts an operand pair.
- `pe_done`  in  1  connected to datapath `delayed_done`.
- `act_BOOTH`  out  1  multiplier start pulse.
- `load_in_exp_PIPO`  out  1  load exponent/sign and operand-2 registers.
- `clr_in_exp_PIPO`  out  1  clear input registers.
- `clr_result_PIPO`  out  1  clear result register and accumulator.
- `clr_status_reg`  out  1  clear overflow/underflow status.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  one-cycle pulse: accumulated result is final.
- `timeout_err`  out  1  sticky error flag.
- `term_idx`  out  CNT_W  index of the current term, 0..K_DEPTH-1.

## Operation
- States: IDLE, CLEAR, FETCH, MUL, WAIT, ACC, DONE, ERR.
- All outputs are Moore-decoded from registered state. The one exception is `load_in_exp_PIPO = (state==FETCH) & operand_valid`.
- **IDLE**
  - All strobes 0.
  - `start` → CLEAR.
  - `term_idx` cleared to 0 on this transition.
- **CLEAR**: `clr_result_PIPO`, `clr_in_exp_PIPO`, `clr_status_reg` all =1 for exactly one cycle. Then → FETCH.
- **FETCH**
  - `operand_ready`=1.
  - On `operand_valid`, the handshake completes at that edge → MUL.
  - Otherwise stay in FETCH indefinitely.
- **MUL**: `act_BOOTH`=1 for one cycle. The wait timer loads 0. Then → WAIT.
- **WAIT**
  - Timer increments each cycle.
  - `pe_done` → ACC.
  - Else if timer == TIMEOUT → ERR.
  - If both happen in the same cycle, `pe_done` wins.
- **ACC**
  - One settling cycle for the accumulator capture.
  - If `term_idx == K_DEPTH-1` → DONE.
  - Else `term_idx` increments and → FETCH.
  - No clears between terms; the accumulator must keep its running sum.
- **DONE**: `result_valid`=1 for one cycle, then → IDLE.
- **ERR**
  - Sets `timeout_err`, then → IDLE.
  - `timeout_err` stays set until the next accepted `start` or `clr`.
- Ignored inputs:
  - `pe_done` outside WAIT.
  - `start` outside IDLE.
- `abort` in any non-IDLE state other than CLEAR → CLEAR, then → IDLE instead of FETCH. A flag remembers the abort path. No `result_valid` is produced.
- `clr` has priority over everything. At the next edge:
  - state = IDLE, `term_idx` = 0, timer = 0, `timeout_err` = 0.
  - All outputs 0.

## Timing
- Reset values: every output is 0, and `term_idx` = 0.
- Cycle-level sequence:
  - `start` sampled at edge 0 → CLEAR during cycle 1.
  - FETCH from cycle 2.
  - With `operand_valid` held high: MUL at cycle 3, WAIT from cycle 4.
- Per-term latency = (FETCH wait + 1) + 1 (MUL) + N (WAIT, N = cycles until `pe_done`) + 1 (ACC).
- Total latency with zero FETCH stall = 1 (CLEAR) + K_DEPTH·(3+N) + 1 (DONE).
- `act_BOOTH` is never asserted twice without an intervening `pe_done`, ERR, or abort.
- `load_in_exp_PIPO` and `operand_ready` are high together only in FETCH. `load_in_exp_PIPO` is exactly one cycle per term.
- `busy` falls in the cycle after DONE or ERR.

## Test plan
- **Reset**: `clr`=1 for 2 cycles mid-WAIT → all outputs 0 and `term_idx`=0 the next cycle; `timeout_err` cleared.
- **Nominal, K_DEPTH=4**: `pe_done` modeled 10 cycles after each `act_BOOTH`, `operand_valid` held high → 4 `act_BOOTH` pulses, 4 `load_in_exp_PIPO` pulses, one `clr_result_PIPO`, and `result_valid` at cycle 1+4·13+1=54 after `start`.
- **Backpressure**: `operand_valid` low for 5 cycles in term 2 → FETCH holds, `act_BOOTH` for term 2 is delayed exactly 5 cycles, no extra clears.
- **Timeout**: `pe_done` never asserted, TIMEOUT=31 → ERR is entered after 31 WAIT cycles; `timeout_err`=1 persists in IDLE and clears on the next `start`.
- **Simultaneous events**:
  - `pe_done` in the same cycle the timer hits TIMEOUT → ACC, not ERR.
  - Spurious `pe_done` in FETCH is ignored.
  - `start` while busy is ignored.
- **Abort**: `abort` in WAIT of term 1 → CLEAR strobes for one cycle, then IDLE; no `result_valid`, `busy` low 2 cycles after `abort`.

Source files
------------

// File: rtl/pe_sequencer.sv
// -----------------------------------------------------------------------------
// pe_sequencer
//
// Control FSM for one systolic processing element. It sequences one K-term
// multiply-accumulate on ProcessingElement_DATAPATH: a single clear of the
// result/input/status registers, then K_DEPTH rounds of
// operand fetch -> Booth multiply -> wait for delayed_done -> accumulate.
//
// Parameters
//   K_DEPTH  products accumulated per result (>= 1)
//   CNT_W    width of term_idx, 2**CNT_W >= K_DEPTH
//   TIMEOUT  maximum number of WAIT cycles before the error path (1..255)
//
// Ports
//   clk              in   clock, rising edge
//   clr              in   synchronous active-high reset, highest priority
//   start            in   begin an accumulation (sampled in IDLE only)
//   abort            in   abandon the operation, exit through CLEAR to IDLE
//   operand_valid    in   upstream presents in1/in2 to the datapath
//   operand_ready    out  sequencer accepts an operand pair (FETCH)
//   pe_done          in   datapath delayed_done (looked at in WAIT only)
//   act_BOOTH        out  multiplier start pulse
//   load_in_exp_PIPO out  load exponent/sign and operand-2 registers
//   clr_in_exp_PIPO  out  clear input registers
//   clr_result_PIPO  out  clear result register and accumulator
//   clr_status_reg   out  clear overflow/underflow status
//   busy             out  high in every state except IDLE
//   result_valid     out  one-cycle pulse, accumulated result is final
//   timeout_err      out  sticky error, cleared by an accepted start or clr
//   term_idx         out  index of the current term, 0..K_DEPTH-1
//   state_dbg        out  current FSM state encoding, for observation only
//
// Handshake: the operand transfer happens at a rising edge where the FSM is
// in FETCH (operand_ready=1) and operand_valid=1. operand_ready does not
// depend on operand_valid; operand_valid may be held or dropped freely while
// operand_ready is low.
// -----------------------------------------------------------------------------
module pe_sequencer #(
  parameter int K_DEPTH = 4,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             abort,
  input  logic             operand_valid,
  output logic             operand_ready,
  input  logic             pe_done,
  output logic             act_BOOTH,
  output logic             load_in_exp_PIPO,
  output logic             clr_in_exp_PIPO,
  output logic             clr_result_PIPO,
  output logic             clr_status_reg,
  output logic             busy,
  output logic             result_valid,
  output logic             timeout_err,
  output logic [CNT_W-1:0] term_idx,
  output logic [2:0]       state_dbg
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_ACC   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  // TIMEOUT is below 256, so an 8-bit wait timer never wraps before ERR.
  localparam int               TMR_W     = 8;
  localparam logic [TMR_W-1:0] TIMEOUT_V = TMR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(K_DEPTH - 1);
  localparam logic [CNT_W-1:0] IDX_ONE   = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_inc;
  logic             abort_pend;
  logic             take_abort;
  logic             start_acc;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // abort is honoured everywhere except IDLE (nothing to abandon) and CLEAR
  // (already on the way out, and the clear strobes must stay one cycle).
  assign take_abort = abort && (state != S_IDLE) && (state != S_CLEAR);
  assign start_acc  = (state == S_IDLE) && start;

  // The timer holds the number of WAIT cycles already completed; timer_inc
  // counts the current WAIT cycle too, so ERR follows exactly TIMEOUT WAIT
  // cycles without pe_done.
  assign timer_inc = timer + TMR_W'(1);

  always_comb begin
    state_nxt = state;
    if (take_abort) begin
      state_nxt = S_CLEAR;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state_nxt = S_CLEAR;
        end
        S_CLEAR: begin
          // After an abort the clear is the exit path, not a new operation.
          state_nxt = abort_pend ? S_IDLE : S_FETCH;
        end
        S_FETCH: begin
          if (operand_valid) state_nxt = S_MUL;
        end
        S_MUL: begin
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          // pe_done wins over a timeout reached in the same cycle.
          if (pe_done) begin
            state_nxt = S_ACC;
          end else if (timer_inc == TIMEOUT_V) begin
            state_nxt = S_ERR;
          end
        end
        S_ACC: begin
          state_nxt = (term_idx == LAST_IDX) ? S_DONE : S_FETCH;
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        S_ERR: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath-control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= S_IDLE;
      term_idx    <= '0;
      timer       <= '0;
      abort_pend  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;

      // A new accumulation restarts the term count and forgets old errors.
      if (start_acc) begin
        term_idx    <= '0;
        timeout_err <= 1'b0;
      end else if ((state == S_ACC) && (state_nxt == S_FETCH)) begin
        term_idx <= term_idx + IDX_ONE;
      end

      if (state == S_MUL) begin
        timer <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer_inc;
      end

      if (take_abort) begin
        abort_pend <= 1'b1;
      end else if (state == S_CLEAR) begin
        abort_pend <= 1'b0;
      end

      // Raised on entry to ERR so the flag is already visible during ERR.
      if ((state == S_WAIT) && (state_nxt == S_ERR)) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode (load_in_exp_PIPO also qualifies with operand_valid
  // so it marks exactly the handshake cycle)
  // ---------------------------------------------------------------------------
  assign operand_ready    = (state == S_FETCH);
  assign load_in_exp_PIPO = (state == S_FETCH) && operand_valid;
  assign act_BOOTH        = (state == S_MUL);
  assign clr_in_exp_PIPO  = (state == S_CLEAR);
  assign clr_result_PIPO  = (state == S_CLEAR);
  assign clr_status_reg   = (state == S_CLEAR);
  assign busy             = (state != S_IDLE);
  assign result_valid     = (state == S_DONE);
  assign state_dbg        = state;

endmodule

// File: tb/tb_pe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pe_sequencer
//
// Directed bench for pe_sequencer with K_DEPTH=4, TIMEOUT=31. Cycle numbers
// in the expectations are relative to the cycle in which start is high
// (cycle 0), so CLEAR is cycle 1 and the first MUL is cycle 3.
// A small datapath model raises pe_done exactly done_lat cycles after each
// act_BOOTH cycle.
// -----------------------------------------------------------------------------
module tb_pe_sequencer;

  localparam int K_DEPTH = 4;
  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 31;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic             abort;
  logic             operand_valid;
  logic             pe_done;
  logic             operand_ready;
  logic             act_BOOTH;
  logic             load_in_exp_PIPO;
  logic             clr_in_exp_PIPO;
  logic             clr_result_PIPO;
  logic             clr_status_reg;
  logic             busy;
  logic             result_valid;
  logic             timeout_err;
  logic [CNT_W-1:0] term_idx;
  logic [2:0]       state_dbg;

  always #5 clk = ~clk;

  pe_sequencer #(
    .K_DEPTH(K_DEPTH),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .clr             (clr),
    .start           (start),
    .abort           (abort),
    .operand_valid   (operand_valid),
    .operand_ready   (operand_ready),
    .pe_done         (pe_done),
    .act_BOOTH       (act_BOOTH),
    .load_in_exp_PIPO(load_in_exp_PIPO),
    .clr_in_exp_PIPO (clr_in_exp_PIPO),
    .clr_result_PIPO (clr_result_PIPO),
    .clr_status_reg  (clr_status_reg),
    .busy            (busy),
    .result_valid    (result_valid),
    .timeout_err     (timeout_err),
    .term_idx        (term_idx),
    .state_dbg       (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  int cyc      = 0;
  int base     = 0;
  int since    = -1;
  int done_lat = 10;
  bit done_en  = 1'b1;

  int n_booth, n_load, n_clr_res, n_clr_in, n_clr_st, n_rv;
  int rv_rel, busy_last, clr_last, bad_load;
  int booth_rel[8];

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mon_reset();
    n_booth   = 0;
    n_load    = 0;
    n_clr_res = 0;
    n_clr_in  = 0;
    n_clr_st  = 0;
    n_rv      = 0;
    rv_rel    = -1;
    busy_last = -1;
    clr_last  = -1;
    bad_load  = 0;
    since     = -1;
    for (int i = 0; i < 8; i++) booth_rel[i] = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: sample the current cycle at the falling edge, then advance one
  // rising edge and update the pe_done model.
  // ---------------------------------------------------------------------------
  task automatic step();
    int r;
    @(negedge clk);
    r = cyc - base;
    if (act_BOOTH) begin
      if (n_booth < 8) booth_rel[n_booth] = r;
      n_booth++;
      since = 0;
    end
    if (load_in_exp_PIPO) n_load++;
    if (load_in_exp_PIPO && !operand_ready) bad_load++;
    if (clr_result_PIPO) begin
      n_clr_res++;
      clr_last = r;
    end
    if (clr_in_exp_PIPO) n_clr_in++;
    if (clr_status_reg) n_clr_st++;
    if (result_valid) begin
      n_rv++;
      rv_rel = r;
    end
    if (busy) busy_last = r;
    @(posedge clk);
    #1;
    cyc++;
    if (since >= 0) since++;
    pe_done = done_en && (since == done_lat);
  endtask

  // One accumulation of ncyc cycles. stall drops operand_valid in cycles
  // 15..19 (term 2 FETCH), spur pulses pe_done in cycle 17 (FETCH),
  // abort_at raises abort in that cycle, poke_start holds start in 30..32.
  task automatic run_op(input int ncyc, input bit stall, input bit spur,
                        input int abort_at, input bit poke_start);
    int r;
    mon_reset();
    start         = 1'b1;
    operand_valid = 1'b1;
    base          = cyc;
    for (int i = 0; i < ncyc; i++) begin
      step();
      r             = cyc - base;
      start         = poke_start && (r >= 30) && (r <= 32);
      operand_valid = !(stall && (r >= 15) && (r <= 19));
      abort         = (r == abort_at);
      if (spur && (r == 17)) pe_done = 1'b1;
      if (r == 1) begin
        check("clear_strobe_c1", 32'(clr_result_PIPO), 32'd1);
        check("terr_low_in_clear", 32'(timeout_err), 32'd0);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({operand_ready, act_BOOTH, load_in_exp_PIPO, clr_in_exp_PIPO,
                clr_result_PIPO, clr_status_reg, busy, result_valid,
                timeout_err, term_idx});
  endfunction

  task automatic check_booths(input string tag);
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() > 0) check(tag, 32'(booth_rel[i]), exp_q.pop_front());
    end
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    clr           = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    operand_valid = 1'b0;
    pe_done       = 1'b0;
    mon_reset();
    step();
    step();
    check("reset_outputs", out_vec(), 32'd0);
    clr = 1'b0;
    step();

    // Nominal run, start poked while busy.
    done_en  = 1'b1;
    done_lat = 10;
    run_op(60, 1'b0, 1'b0, -1, 1'b1);
    check("nom_result_cycle", 32'(rv_rel), 32'd54);
    check("nom_result_count", 32'(n_rv), 32'd1);
    check("nom_booth_count", 32'(n_booth), 32'd4);
    check("nom_load_count", 32'(n_load), 32'd4);
    check("nom_clr_result", 32'(n_clr_res), 32'd1);
    check("nom_clr_in", 32'(n_clr_in), 32'd1);
    check("nom_clr_status", 32'(n_clr_st), 32'd1);
    check("nom_busy_last", 32'(busy_last), 32'd54);
    check("nom_load_wo_ready", 32'(bad_load), 32'd0);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd16);
    exp_q.push_back(32'd29);
    exp_q.push_back(32'd42);
    check_booths("nom_booth_time");

    // Backpressure in term 2 plus a spurious pe_done during FETCH.
    run_op(65, 1'b1, 1'b1, -1, 1'b0);
    check("bp_result_cycle", 32'(rv_rel), 32'd59);
    check("bp_load_count", 32'(n_load), 32'd4);
    check("bp_clr_result", 32'(n_clr_res), 32'd1);
    check("bp_load_wo_ready", 32'(bad_load), 32'd0);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd21);
    exp_q.push_back(32'd34);
    exp_q.push_back(32'd47);
    check_booths("bp_booth_time");

    // Abort in WAIT of the second term.
    run_op(30, 1'b0, 1'b0, 20, 1'b0);
    check("abort_no_result", 32'(n_rv), 32'd0);
    check("abort_clr_count", 32'(n_clr_res), 32'd2);
    check("abort_clr_in", 32'(n_clr_in), 32'd2);
    check("abort_clr_cycle", 32'(clr_last), 32'd21);
    check("abort_busy_last", 32'(busy_last), 32'd21);
    check("abort_booth_count", 32'(n_booth), 32'd2);

    // Timeout: no pe_done at all.
    done_en = 1'b0;
    run_op(40, 1'b0, 1'b0, -1, 1'b0);
    check("to_busy_last", 32'(busy_last), 32'd35);
    check("to_booth_count", 32'(n_booth), 32'd1);
    check("to_no_result", 32'(n_rv), 32'd0);
    check("to_err_set", 32'(timeout_err), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);

    // Next start clears the flag (checked in cycle 1 inside run_op).
    done_en  = 1'b1;
    done_lat = 1;
    run_op(25, 1'b0, 1'b0, -1, 1'b0);
    check("lat1_result_cycle", 32'(rv_rel), 32'd18);
    check("lat1_err_clear", 32'(timeout_err), 32'd0);

    // pe_done in the 31st WAIT cycle beats the timeout.
    done_lat = 31;
    run_op(145, 1'b0, 1'b0, -1, 1'b0);
    check("edge_result_cycle", 32'(rv_rel), 32'd138);
    check("edge_no_err", 32'(timeout_err), 32'd0);
    check("edge_booth_count", 32'(n_booth), 32'd4);

    // pe_done one cycle too late: ERR after 31 WAIT cycles.
    done_lat = 32;
    run_op(40, 1'b0, 1'b0, -1, 1'b0);
    check("late_busy_last", 32'(busy_last), 32'd35);
    check("late_err_set", 32'(timeout_err), 32'd1);
    check("late_no_result", 32'(n_rv), 32'd0);

    // clr in IDLE clears the sticky error.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_clears_err", 32'(timeout_err), 32'd0);

    // clr held two cycles in WAIT of term 2.
    done_lat = 10;
    run_op(20, 1'b0, 1'b0, -1, 1'b0);
    check("pre_clr_term_idx", 32'(term_idx), 32'd1);
    check("pre_clr_busy", 32'(busy), 32'd1);
    clr = 1'b1;
    step();
    check("midwait_clr_c1", out_vec(), 32'd0);
    step();
    clr = 1'b0;
    check("midwait_clr_c2", out_vec(), 32'd0);
    mon_reset();
    for (int i = 0; i < 10; i++) step();
    check("post_clr_quiet", 32'(n_booth + n_load + n_rv + n_clr_res), 32'd0);
    check("post_clr_idle", 32'(busy_last), 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
